// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one 8-bit combinational ALU (ADD/SUB/AND/NOT) between two requesters.
// An operation is accepted on a valid/ready handshake. Its opcode and operands
// are latched and held on the ALU inputs for one execute cycle. The ALU output
// is then captured into rsp_data and returned on the granted requester's
// response handshake.
//
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
// Without it, requester 0 has fixed priority.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready           request handshake, N = 0,1
//   reqN_op, reqN_a, reqN_b    opcode (00 ADD, 01 SUB, 10 AND, 11 NOT) and operands
//   rspN_valid/ready           response handshake, N = 0,1
//   rsp_data                   registered result, shared by both response channels
//   alu_inp1/alu_inp2/alu_control  driven to the ALU from the operand registers
//   alu_out                    ALU result
//   busy                       high whenever the FSM is not idle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; accept the winning request and latch its operands
// EXEC  | ALU settles from latched operands; capture alu_out at the edge
// RESP  | rsp[gnt]_valid high; wait for rsp[gnt]_ready
module alu_share_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] alu_inp1,
  output logic [7:0] alu_inp2,
  output logic [1:0] alu_control,
  input  logic [7:0] alu_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_gnt;
  logic [1:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_rsp_data;
  logic       r_rsp0_valid;
  logic       r_rsp1_valid;
  logic       r_busy;
`ifdef ARB_ROUND_ROBIN_EN
  logic       r_last_gnt;
`endif

  logic w_idle;
  logic w_pick1;
  logic w_accept;
  logic w_rsp_done;

  // Gated with rst_n so both readies drop immediately while reset is held,
  // even if a requester keeps its valid asserted.
  assign w_idle = (r_state == S_IDLE) && rst_n;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, requester 1 wins only if requester 0 was granted last.
  assign w_pick1 = req1_valid && (!req0_valid || !r_last_gnt);
`else
  assign w_pick1 = req1_valid && !req0_valid;
`endif

  assign req0_ready = w_idle && req0_valid && !w_pick1;
  assign req1_ready = w_idle && w_pick1;
  assign w_accept   = req0_ready || req1_ready;
  assign w_rsp_done = r_gnt ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gnt        <= 1'b0;
      r_op         <= 2'b00;
      r_a          <= 8'h00;
      r_b          <= 8'h00;
      r_rsp_data   <= 8'h00;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_gnt   <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gnt   <= w_pick1;
            r_op    <= w_pick1 ? req1_op : req0_op;
            r_a     <= w_pick1 ? req1_a  : req0_a;
            r_b     <= w_pick1 ? req1_b  : req0_b;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_gnt <= w_pick1;
`endif
          end
        end
        S_EXEC: begin
          r_rsp_data   <= alu_out;
          r_rsp0_valid <= !r_gnt;
          r_rsp1_valid <= r_gnt;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_done) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp_data    = r_rsp_data;
  assign alu_inp1    = r_a;
  assign alu_inp2    = r_b;
  assign alu_control = r_op;
  assign busy        = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Bench for alu_share_arbiter, with a behavioural ALU attached to the ALU
// ports. It applies a table of directed operations, hand-written sequences
// for ties, backpressure, reset and operand changes, and randomized requests
// checked against a transaction-level reference model.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready, rsp1_ready;
  logic [7:0] rsp_data;
  logic [7:0] alu_inp1, alu_inp2;
  logic [1:0] alu_control;
  logic [7:0] alu_out;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  logic m_last;  // model of last grant (round-robin), 1 after reset

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
    .alu_control(alu_control), .alu_out(alu_out), .busy(busy)
  );

  // Behavioural ALU.
  always_comb begin
    alu_out = 8'h00;
    case (alu_control)
      2'b00: alu_out = alu_inp1 + alu_inp2;
      2'b01: alu_out = alu_inp1 - alu_inp2;
      2'b10: alu_out = alu_inp1 & alu_inp2;
      2'b11: alu_out = ~alu_inp2;
      default: alu_out = 8'h00;
    endcase
  end

  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int r;
    case (op)
      2'b00:   r = int'(a) + int'(b);
      2'b01:   r = int'(a) - int'(b) + 256;
      2'b10:   r = int'(a & b);
      default: r = 255 - int'(b);
    endcase
    return 8'(r % 256);
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;  // valids high during reset: readies must still be 0
    req1_valid = 1'b1;
    #2;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk1("rst_rsp0", rsp0_valid, 1'b0);
    chk1("rst_rsp1", rsp1_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_data", rsp_data, 8'h00);
    chk8("rst_inp1", alu_inp1, 8'h00);
    chk8("rst_inp2", alu_inp2, 8'h00);
    chk8("rst_ctrl", {6'b0, alu_control}, 8'h00);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1;
    @(posedge clk); #1;
  endtask

  // One complete transaction from IDLE back to IDLE. Entered shortly after a
  // rising edge with the DUT idle. If use_exp is 0 the result comes from the
  // reference model.
  task automatic serve(input logic v0, input logic v1,
                       input logic [1:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [1:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                       input int hold, input logic use_exp, input logic [7:0] exp_in);
    logic w;
    logic [1:0] eop;
    logic [7:0] ea, eb, er;
`ifdef ARB_ROUND_ROBIN_EN
    w = (v0 && v1) ? !m_last : v1;
`else
    w = !v0;
`endif
    m_last = w;
    eop = w ? op1 : op0;
    ea  = w ? a1 : a0;
    eb  = w ? b1 : b0;
    er  = use_exp ? exp_in : ref_alu(eop, ea, eb);

    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    chk1("acc_ready0", req0_ready, !w);
    chk1("acc_ready1", req1_ready, w);
    if (hold > 0) begin
      if (w) rsp1_ready = 1'b0; else rsp0_ready = 1'b0;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~req0_a; req1_b = ~req1_b; req0_op = ~req0_op;  // must not affect result
    chk1("exec_busy", busy, 1'b1);
    chk1("exec_rsp_any", rsp0_valid | rsp1_valid, 1'b0);
    chk8("exec_inp1", alu_inp1, ea);
    chk8("exec_inp2", alu_inp2, eb);
    chk8("exec_ctrl", {6'b0, alu_control}, {6'b0, eop});
    @(posedge clk); #1;
    chk1("resp_valid_w", w ? rsp1_valid : rsp0_valid, 1'b1);
    chk1("resp_valid_o", w ? rsp0_valid : rsp1_valid, 1'b0);
    chk8("resp_data", rsp_data, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk1("hold_valid", w ? rsp1_valid : rsp0_valid, 1'b1);
      chk8("hold_data", rsp_data, er);
    end
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk); #1;
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_rsp0", rsp0_valid, 1'b0);
    chk1("idle_rsp1", rsp1_valid, 1'b0);
    chk8("idle_inp1", alu_inp1, ea);
    chk8("idle_data", rsp_data, er);
  endtask

  typedef struct {
    logic       rq;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[7];
  logic tie_exp[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    m_last = 1'b1;

    vt[0] = '{1'b0, 2'b00, 8'hF0, 8'h20, 8'h10};
    vt[1] = '{1'b1, 2'b01, 8'h05, 8'h07, 8'hFE};
    vt[2] = '{1'b1, 2'b10, 8'hCC, 8'hAA, 8'h88};
    vt[3] = '{1'b1, 2'b11, 8'hFF, 8'h0F, 8'hF0};
    vt[4] = '{1'b0, 2'b00, 8'hFF, 8'h01, 8'h00};
    vt[5] = '{1'b0, 2'b01, 8'h00, 8'h01, 8'hFF};
    vt[6] = '{1'b1, 2'b00, 8'h7F, 8'h01, 8'h80};

    #3;
    do_reset();

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      if (vt[i].rq)
        serve(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, vt[i].op, vt[i].a, vt[i].b, 0, 1'b1, vt[i].exp);
      else
        serve(1'b1, 1'b0, vt[i].op, vt[i].a, vt[i].b, 2'b00, 8'h00, 8'h00, 0, 1'b1, vt[i].exp);
    end

    // Tie with both valids held across four operations.
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    tie_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    tie_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    req0_op = 2'b00; req0_a = 8'h01; req0_b = 8'h02;
    req1_op = 2'b01; req1_a = 8'h09; req1_b = 8'h04;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("tie_ready0", req0_ready, !tie_exp[i]);
      chk1("tie_ready1", req1_ready, tie_exp[i]);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk1("tie_rsp0", rsp0_valid, !tie_exp[i]);
      chk1("tie_rsp1", rsp1_valid, tie_exp[i]);
      chk8("tie_data", rsp_data, tie_exp[i] ? 8'h05 : 8'h03);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = tie_exp[3];

    // Response backpressure with requester 1 waiting.
    #1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h30; req0_b = 8'h12;
    rsp0_ready = 1'b0;
    #1;
    chk1("bp_ready0", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'hF0; req1_b = 8'h3C;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_rsp0", rsp0_valid, 1'b1);
      chk8("bp_data", rsp_data, 8'h42);
      chk1("bp_ready1", req1_ready, 1'b0);
      chk1("bp_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp_idle_busy", busy, 1'b0);
    chk1("bp_idle_rsp0", rsp0_valid, 1'b0);
    chk1("bp_idle_ready1", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    m_last = 1'b1;
    @(posedge clk); #1;
    chk1("bp_r1_rsp1", rsp1_valid, 1'b1);
    chk8("bp_r1_data", rsp_data, 8'h30);
    @(posedge clk); #1;

    // Reset during EXEC.
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h11; req0_b = 8'h22;
    @(posedge clk); #3;
    chk1("rx_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rx_busy", busy, 1'b0);
    chk1("rx_rsp0", rsp0_valid, 1'b0);
    chk1("rx_ready0", req0_ready, 1'b0);
    chk1("rx_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; m_last = 1'b1;
    @(posedge clk); #1;
    serve(1'b1, 1'b0, 2'b01, 8'h40, 8'h41, 2'b00, 8'h00, 8'h00, 0, 1'b1, 8'hFF);

    // Reset during RESP.
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'h11; req1_b = 8'h22;
    rsp1_ready = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #2;
    chk1("rr_rsp1_pre", rsp1_valid, 1'b1);
    rst_n = 1'b0;
    req1_valid = 1'b1;
    #1;
    chk1("rr_rsp1", rsp1_valid, 1'b0);
    chk1("rr_busy", busy, 1'b0);
    chk1("rr_ready1", req1_ready, 1'b0);
    chk8("rr_data", rsp_data, 8'h00);
    req1_valid = 1'b0; rsp1_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1; m_last = 1'b1;
    @(posedge clk); #1;
    serve(1'b0, 1'b1, 2'b00, 8'h0E, 8'h0F, 2'b10, 8'h5A, 8'h0F, 0, 1'b1, 8'h0A);

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      int vp;
      vp = int'($urandom_range(1, 3));
      serve(vp[0], vp[1],
            2'($urandom), 8'($urandom), 8'($urandom),
            2'($urandom), 8'($urandom), 8'($urandom),
            int'($urandom_range(0, 2)), 1'b0, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
